// File: rtl/fpu_adder_arbiter_pkg.sv
// Shared FPU types: IEEE-754 single layout, adder status code, and the
// {valid, id} tag that rides alongside the external adder pipeline.
package fpu_adder_arbiter_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_point_num;

  typedef logic [1:0] fpu_state_t;

  // Wide enough for up to 8 requesters.
  localparam int ID_W = 3;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } fpu_tag_t;

endpackage

// File: rtl/fpu_adder_arbiter_rr.sv
// N-way round-robin arbiter: search starts one past the last winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N-1:0]                         i_req,
  output logic [N-1:0]                         o_gnt,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0]   o_gnt_idx,
  output logic                                 o_gnt_vld
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;

  // First requesting index at or after the pointer, wrapping around.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % N);
      if (!o_gnt_vld && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
        o_gnt_vld    = 1'b1;
      end
    end
  end

  // Pointer moves only when something was granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_ptr <= '0;
    else if (o_gnt_vld) r_ptr <= (o_gnt_idx == IW'(N - 1)) ? '0 : o_gnt_idx + 1'b1;
  end

endmodule

// File: rtl/fpu_adder_arbiter.sv
// Shares one external pipelined FP adder among N_REQ requesters. Grants are
// round-robin, limited to MAX_OUT in-flight ops per requester; a tag shift
// register aligned to the adder latency routes each result back to its owner.
module fpu_adder_arbiter
  import fpu_adder_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 6,
  parameter int MAX_OUT = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic           [N_REQ-1:0]       req_vld,
  input  float_point_num [N_REQ-1:0]       req_a,
  input  float_point_num [N_REQ-1:0]       req_b,
  output logic           [N_REQ-1:0]       req_rdy,
  output logic           [N_REQ-1:0]       rsp_vld,
  output float_point_num                   rsp_result,
  output fpu_state_t                       rsp_state,
  output float_point_num                   add_a,
  output float_point_num                   add_b,
  output logic                             add_vld,
  input  float_point_num                   add_result,
  input  fpu_state_t                       add_res_state,
  output logic                             busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [N_REQ-1:0]           w_elig;
  logic [N_REQ-1:0]           w_gnt;
  logic [IW-1:0]              w_gnt_idx;
  logic                       w_gnt_vld;
  logic                       w_tag_any;
  logic [IW-1:0]              r_issue_id;
  fpu_tag_t [LATENCY-1:0]     r_tag;
  logic [N_REQ-1:0][CW-1:0]   r_cnt;

  // Eligible = asking and below its in-flight cap; nothing is granted in reset.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_REQ; i++)
      w_elig[i] = !rst && req_vld[i] && (r_cnt[i] < CW'(MAX_OUT));
  end

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_elig),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  assign req_rdy = w_gnt;

  // Issue register: the granted operands go to the adder one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_vld    <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      r_issue_id <= '0;
    end else begin
      add_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        add_a      <= req_a[w_gnt_idx];
        add_b      <= req_b[w_gnt_idx];
        r_issue_id <= w_gnt_idx;
      end
    end
  end

  // Tag pipe: last stage lines up with add_result for the same operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= '{vld: add_vld, id: ID_W'(r_issue_id)};
      for (int k = 1; k < LATENCY; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  // Response register: capture the adder output only under a valid tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld    <= '0;
      rsp_result <= '0;
      rsp_state  <= '0;
    end else begin
      rsp_vld <= '0;
      if (r_tag[LATENCY-1].vld) begin
        rsp_vld    <= N_REQ'(1) << r_tag[LATENCY-1].id;
        rsp_result <= add_result;
        rsp_state  <= add_res_state;
      end
    end
  end

  // In-flight counters: +1 on grant, -1 on response, unchanged when both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        case ({w_gnt[i], rsp_vld[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  // Any valid tag anywhere in the pipe.
  always_comb begin
    w_tag_any = 1'b0;
    for (int k = 0; k < LATENCY; k++) w_tag_any = w_tag_any | r_tag[k].vld;
  end

  assign busy = add_vld | w_tag_any | (|rsp_vld);

endmodule
